ram_phase_ctrl: RTL
===================

Name: ram_phase_ctrl

Overview:
- Single-clock sequencer that owns the shared image RAM for one down-sample frame, in three phases: UART receive, processing, UART transmit.
- Replaces clock-muxed RAM selection. All RAM traffic runs on real_clk; requesters are granted the RAM by FSM state instead of by switching clocks.
- Sits between uart_rx, the down-sample processor, uart_tx and the single-port RAM.

Parameters:
- ADDR_W, 16, RAM address width.
- IN_BYTES, 16384, bytes received per frame; written to addresses 0..IN_BYTES-1.
- OUT_BASE, 16384, first RAM address of processor output.
- OUT_BYTES, 4096, bytes transmitted per frame, read from OUT_BASE..OUT_BASE+OUT_BYTES-1.

Ports:
- real_clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- proc_start  out  1  one-cycle pulse that starts the processor.
- proc_done  in  1  one-cycle pulse, processor finished.
- proc_we  in  1  processor RAM write enable.
- proc_addr  in  ADDR_W  processor RAM address.
- proc_din  in  8  processor write data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, 1-cycle synchronous read latency.
- tx_start  out  1  one-cycle pulse to uart_tx.
- tx_data  out  8  byte for uart_tx, held stable from tx_start until tx_busy falls.
- tx_busy  in  1  uart_tx busy.
- restart  in  1  start the next frame from DONE.
- phase  out  2  status: 0 RX, 1 PROC, 2 TX, 3 DONE.
- frame_done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async, rst_n=0): state S_RX. All counters 0. ram_we=0, ram_addr=0, ram_din=0, proc_start=0, tx_start=0, tx_data=0, phase=0, frame_done=0. Reset mid-frame discards the frame; RAM contents are not cleared.
- S_RX (phase 0):
  - On rx_valid, next cycle: ram_we=1, ram_addr=wr_cnt, ram_din=rx_data (1-cycle registered latency). Then wr_cnt++.
  - When the write of byte IN_BYTES-1 issues, go to S_PSTART.
  - rx_valid on consecutive cycles is accepted back-to-back.
- S_PSTART: proc_start=1 for exactly one cycle, then S_PROC.
- S_PROC (phase 1):
  - Combinational pass-through: ram_we=proc_we, ram_addr=proc_addr, ram_din=proc_din.
  - proc_done goes to S_TXRD. proc_done in any other state is ignored.
- S_TXRD (phase 2): ram_addr=OUT_BASE+rd_cnt, ram_we=0, then S_TXLAT.
- S_TXLAT: wait out the RAM read latency.
- S_TXSEND:
  - Capture ram_dout into tx_data.
  - Pulse tx_start only if tx_busy=0; otherwise hold in S_TXSEND.
  - After the pulse go to S_TXBUSY.
- S_TXBUSY:
  - Ignore tx_busy in the first cycle after tx_start.
  - Then wait for tx_busy=0 and increment rd_cnt.
  - If rd_cnt reaches OUT_BYTES go to S_DONE, else S_TXRD.
- S_DONE (phase 3): frame_done pulses on entry. restart=1 clears counters and returns to S_RX.
- Ignored inputs: rx_valid outside S_RX, proc_we outside S_PROC, restart outside S_DONE. Ignored rx bytes are dropped silently.
- Width: counters are ADDR_W+1 bits, so IN_BYTES=2^ADDR_W cannot wrap. The OUT_BASE+rd_cnt sum is truncated to ADDR_W.
- Outside S_PROC, ram_we is only ever driven by the S_RX path.

Optional Feature:
- Macro: RAM_PHASE_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum accumulates every transmitted byte; it is cleared on S_RX entry.
  - After the last data byte, one extra byte equal to the sum is sent through the same tx_start/tx_busy handshake, before S_DONE.
  - Total bytes sent = OUT_BYTES+1.
- Undefined: no checksum logic; exactly OUT_BYTES bytes are sent.

Decomposition:
- Package ram_phase_pkg: state encoding (S_RX, S_PSTART, S_PROC, S_TXRD, S_TXLAT, S_TXSEND, S_TXBUSY, S_DONE) and phase codes (PH_RX=0, PH_PROC=1, PH_TX=2, PH_DONE=3).
- One sub-module: tx_streamer. It owns rd_cnt, the read/latency/send/busy loop and the optional checksum. It is started by the top FSM and returns a done pulse.

Test Plan:
- IN_BYTES=4, OUT_BYTES=2, OUT_BASE=8. Send rx bytes 0x11,0x22,0x33,0x44 with gaps -> ram writes to addr 0..3 with those data, one cycle after each rx_valid; one proc_start pulse after the 4th write.
- Same config, 4 rx_valid back-to-back -> 4 consecutive ram_we cycles, no drop; stray rx_valid during PROC -> no ram_we.
- PROC: processor writes 0xAB@8 and 0xCD@9, then proc_done -> ram mirrors proc signals; TX reads 8,9; tx_data 0xAB then 0xCD; tx_start only while tx_busy=0.
- Hold tx_busy=1 for 20 cycles after each tx_start -> next tx_start no earlier than 2 cycles after tx_busy falls; frame_done pulses once; phase=3.
- Assert rst_n=0 mid-TX -> all outputs 0 immediately, phase=0; the next frame is received from address 0.
- With RAM_PHASE_TX_CHECKSUM_EN -> third tx byte is 0x78 (0xAB+0xCD mod 256); without it only 2 bytes are sent.

Source files
------------

// File: rtl/ram_phase_pkg.sv
// ram_phase_pkg: shared encodings for the image-RAM phase sequencer.
//   state_e : sequencer states (top FSM uses S_RX..S_TXRD/S_DONE, the
//             tx_streamer walks S_TXRD..S_TXBUSY and idles in S_DONE)
//   PH_*    : codes driven on the phase status output
package ram_phase_pkg;

  typedef enum logic [2:0] {
    S_RX, S_PSTART, S_PROC, S_TXRD, S_TXLAT, S_TXSEND, S_TXBUSY, S_DONE
  } state_e;

  localparam logic [1:0] PH_RX   = 2'd0;
  localparam logic [1:0] PH_PROC = 2'd1;
  localparam logic [1:0] PH_TX   = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

endpackage

// File: rtl/ram_phase_ctrl_tx_streamer.sv
// tx_streamer: reads OUT_BYTES bytes from OUT_BASE.. and hands each one to
// uart_tx with a tx_start/tx_busy handshake.
// Optional macro RAM_PHASE_TX_CHECKSUM_EN appends a mod-256 sum byte.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i             one-cycle kick from the top FSM
//   clr_i               clear read counter / checksum for the next frame
//   ram_addr_o          read address (OUT_BASE + rd_cnt, truncated)
//   ram_dout_i          RAM read data, 1-cycle latency
//   tx_start_o, tx_data_o, tx_busy_i   uart_tx handshake
//   done_o              one-cycle pulse: last byte fully handed off
module tx_streamer
  import ram_phase_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned OUT_BASE  = 16384,
  parameter int unsigned OUT_BYTES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [7:0]        ram_dout_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  output logic              done_o
);

  state_e          st_q;
  logic [ADDR_W:0] rd_cnt_q, rd_cnt_inc;
  logic            tx_start_q, guard_q;
  logic [7:0]      tx_data_q;
  logic            send, adv, last_data;

  assign rd_cnt_inc = rd_cnt_q + 1'b1;
  assign last_data  = (rd_cnt_inc == (ADDR_W+1)'(OUT_BYTES));
  assign ram_addr_o = ADDR_W'(OUT_BASE) + rd_cnt_q[ADDR_W-1:0];
  assign send       = (st_q == S_TXSEND) && !tx_busy_i;
  // tx_busy is only trusted from the second cycle after the pulse, so a
  // uart that raises busy a cycle late cannot be mistaken for "finished".
  assign adv        = (st_q == S_TXBUSY) && !tx_start_q && !guard_q && !tx_busy_i;

`ifdef RAM_PHASE_TX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
  logic [7:0] sum_q;
  logic       ck_q;   // byte in flight is the checksum, not RAM data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      ck_q  <= 1'b0;
    end else if (clr_i) begin
      sum_q <= '0;
      ck_q  <= 1'b0;
    end else begin
      if (send && !ck_q)              sum_q <= sum_q + ram_dout_i;
      if (adv && last_data && !ck_q)  ck_q  <= 1'b1;
    end
  end
`else
  localparam bit CK_EN = 1'b0;
  logic [7:0] sum_q;
  logic       ck_q;
  assign sum_q = '0;
  assign ck_q  = 1'b0;
`endif

  assign done_o     = adv && (CK_EN ? ck_q : last_data);
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= S_DONE;
      rd_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      guard_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (clr_i) rd_cnt_q <= '0;
      case (st_q)
        S_TXRD:  st_q <= S_TXLAT;
        S_TXLAT: st_q <= S_TXSEND;
        S_TXSEND: if (send) begin
          tx_data_q  <= ck_q ? sum_q : ram_dout_i;
          tx_start_q <= 1'b1;
          guard_q    <= 1'b1;
          st_q       <= S_TXBUSY;
        end
        S_TXBUSY: begin
          if (!tx_start_q && guard_q) guard_q <= 1'b0;
          if (adv) begin
            if (ck_q) st_q <= S_DONE;
            else begin
              rd_cnt_q <= rd_cnt_inc;
              // checksum byte needs no RAM read: go straight to send
              if (last_data) st_q <= CK_EN ? S_TXSEND : S_DONE;
              else           st_q <= S_TXRD;
            end
          end
        end
        default: if (start_i) st_q <= S_TXRD;
      endcase
    end
  end

endmodule

// File: rtl/ram_phase_ctrl.sv
// ram_phase_ctrl: owns the single-port image RAM for one frame in three
// phases (UART receive -> processor -> UART transmit), all on real_clk.
// Optional macro RAM_PHASE_TX_CHECKSUM_EN (in tx_streamer) appends a sum byte.
// Ports:
//   real_clk, rst_n                      clock, async active-low reset
//   rx_valid, rx_data                    uart_rx byte strobe
//   proc_start, proc_done                processor kick / finish pulses
//   proc_we, proc_addr, proc_din         processor RAM port (PROC only)
//   ram_we, ram_addr, ram_din, ram_dout  single-port RAM
//   tx_start, tx_data, tx_busy           uart_tx handshake
//   restart                              start next frame from DONE
//   phase, frame_done                    status
module ram_phase_ctrl
  import ram_phase_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IN_BYTES  = 16384,
  parameter int unsigned OUT_BASE  = 16384,
  parameter int unsigned OUT_BYTES = 4096
) (
  input  logic              real_clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              proc_start,
  input  logic              proc_done,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_din,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              restart,
  output logic [1:0]        phase,
  output logic              frame_done
);

  // S_TXRD is held for the whole transmit phase; tx_streamer runs the
  // per-byte read/latency/send/busy loop underneath it.
  state_e            state_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              ram_we_q, proc_start_q, frame_done_q;
  logic [ADDR_W-1:0] ram_addr_q, tx_addr;
  logic [7:0]        ram_din_q;
  logic              tx_go, tx_clr, tx_done;

  assign tx_go  = (state_q == S_PROC) && proc_done;
  assign tx_clr = (state_q == S_DONE) && restart;

  tx_streamer #(
    .ADDR_W(ADDR_W), .OUT_BASE(OUT_BASE), .OUT_BYTES(OUT_BYTES)
  ) u_tx (
    .clk_i(real_clk), .rst_ni(rst_n), .start_i(tx_go), .clr_i(tx_clr),
    .ram_addr_o(tx_addr), .ram_dout_i(ram_dout),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .done_o(tx_done)
  );

  always_ff @(posedge real_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RX;
      wr_cnt_q     <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      proc_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ram_we_q     <= 1'b0;
      proc_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_RX: if (rx_valid) begin
          ram_we_q   <= 1'b1;
          ram_addr_q <= wr_cnt_q[ADDR_W-1:0];
          ram_din_q  <= rx_data;
          wr_cnt_q   <= wr_cnt_q + 1'b1;
          // last write is still on the RAM port during S_PSTART
          if (wr_cnt_q == (ADDR_W+1)'(IN_BYTES - 1)) state_q <= S_PSTART;
        end
        S_PSTART: begin
          proc_start_q <= 1'b1;
          state_q      <= S_PROC;
        end
        S_PROC: if (proc_done) state_q <= S_TXRD;
        S_TXRD: if (tx_done) begin
          frame_done_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: if (restart) begin
          wr_cnt_q <= '0;
          state_q  <= S_RX;
        end
        default: state_q <= S_RX;
      endcase
    end
  end

  // RAM port ownership by state; only the RX path writes outside S_PROC.
  always_comb begin
    ram_we   = ram_we_q;
    ram_addr = ram_addr_q;
    ram_din  = ram_din_q;
    phase    = PH_RX;
    case (state_q)
      S_PSTART: phase = PH_PROC;
      S_PROC: begin
        phase    = PH_PROC;
        ram_we   = proc_we;
        ram_addr = proc_addr;
        ram_din  = proc_din;
      end
      S_TXRD: begin
        phase    = PH_TX;
        ram_we   = 1'b0;
        ram_addr = tx_addr;
      end
      S_DONE:  phase = PH_DONE;
      default: phase = PH_RX;
    endcase
  end

  assign proc_start = proc_start_q;
  assign frame_done = frame_done_q;

endmodule
